// File: rtl/aes_bus_master_pkg.sv
// Shared types for the AES bus master: FSM state encoding, bus word and
// block types, and the number of words making up one 128-bit block.
package aes_bus_master_pkg;

    localparam int WORD_BITS       = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int BLOCK_BITS      = WORD_BITS * WORDS_PER_BLOCK;

    typedef logic [WORD_BITS-1:0]  word_t;
    typedef logic [BLOCK_BITS-1:0] block_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_KEY = 3'd1,
        ST_LOAD_PT  = 3'd2,
        ST_WAIT_CT  = 3'd3,
        ST_RESP     = 3'd4
    } aes_bm_state_t;

endpackage

// File: rtl/aes_word_serdes.sv
// Four-word register file with a 2-bit word index.
// Used either as a shift-out buffer (parallel load, present word[idx],
// advance on transfer) or as a gather buffer (write word[idx], advance).
// Ports:
//   clk, resetN        clock, async active-low reset
//   clr                zero all words and the index
//   load, load_data    parallel load of a whole block, index back to 0
//   adv                advance the index without writing
//   wr, wr_data        write word[idx] and advance the index
//   word               word currently selected by the index
//   block              all four words, word 0 in bits [31:0]
//   last               index points at word 3
module aes_word_serdes
    import aes_bus_master_pkg::*;
(
    input  logic   clk,
    input  logic   resetN,
    input  logic   clr,
    input  logic   load,
    input  block_t load_data,
    input  logic   adv,
    input  logic   wr,
    input  word_t  wr_data,
    output word_t  word,
    output block_t block,
    output logic   last
);

    word_t      regs_r [WORDS_PER_BLOCK];
    logic [1:0] idx_r;

    // Word storage and index; clear beats load beats write beats advance.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                regs_r[i] <= '0;
            end
            idx_r <= 2'd0;
        end else if (clr) begin
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                regs_r[i] <= '0;
            end
            idx_r <= 2'd0;
        end else if (load) begin
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                regs_r[i] <= load_data[i*WORD_BITS +: WORD_BITS];
            end
            idx_r <= 2'd0;
        end else if (wr) begin
            regs_r[idx_r] <= wr_data;
            idx_r         <= idx_r + 2'd1;
        end else if (adv) begin
            // 2-bit index wraps 3 -> 0 on the final transfer of a phase
            idx_r <= idx_r + 2'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    assign word  = regs_r[idx_r];
    assign block = {regs_r[3], regs_r[2], regs_r[1], regs_r[0]};
    assign last  = (idx_r == 2'd3);

endmodule

// File: rtl/aes_bus_master.sv
// Bus initiator for the AES core: takes one command (key + plaintext),
// streams the key (unless a previously loaded key is reused) and the
// plaintext as 32-bit words, gathers four ciphertext words and returns the
// assembled block. A WAIT_CT timeout aborts with rsp_err=1, rsp_ct=0.
// Ports:
//   clk, resetN                 clock, async active-low reset
//   cmd_*                       command port (valid/ready, key, pt, reuse flag)
//   key_valid/ready/data/last   key bus, word 0 first, last marks word 3
//   pt_valid/ready/data         plaintext bus
//   ct_valid/ready/data         ciphertext bus (inbound)
//   rsp_valid/ready/ct/err      response port
// Every output is decoded from the state register and internal registers
// only, so there is no combinational input-to-output path.
module aes_bus_master
    import aes_bus_master_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [4*WORD_W-1:0]   cmd_key,
    input  logic [4*WORD_W-1:0]   cmd_pt,
    input  logic                  cmd_reuse_key,
    output logic                  key_valid,
    input  logic                  key_ready,
    output logic [WORD_W-1:0]     key_data,
    output logic                  key_last,
    output logic                  pt_valid,
    input  logic                  pt_ready,
    output logic [WORD_W-1:0]     pt_data,
    input  logic                  ct_valid,
    output logic                  ct_ready,
    input  logic [WORD_W-1:0]     ct_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [4*WORD_W-1:0]   rsp_ct,
    output logic                  rsp_err
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    aes_bm_state_t   state_r;
    aes_bm_state_t   next_state_s;
    block_t          pt_hold_r;
    logic            key_loaded_r;
    logic [TO_W-1:0] to_cnt_r;
    logic            rsp_err_r;

    logic   accept_s;
    logic   key_done_s;
    logic   timeout_s;
    logic   out_load_s;
    block_t out_load_data_s;
    logic   out_adv_s;
    word_t  out_word_s;
    logic   out_last_s;
    block_t out_block_unused_s;
    logic   ct_clr_s;
    logic   ct_wr_s;
    word_t  ct_word_unused_s;
    block_t ct_block_s;
    logic   ct_last_s;

    // Shift-out buffer: holds the key, then is reloaded with the plaintext.
    aes_word_serdes u_out (
        .clk       (clk),
        .resetN    (resetN),
        .clr       (1'b0),
        .load      (out_load_s),
        .load_data (out_load_data_s),
        .adv       (out_adv_s),
        .wr        (1'b0),
        .wr_data   ('0),
        .word      (out_word_s),
        .block     (out_block_unused_s),
        .last      (out_last_s)
    );

    // Gather buffer for the returned ciphertext words.
    aes_word_serdes u_ct (
        .clk       (clk),
        .resetN    (resetN),
        .clr       (ct_clr_s),
        .load      (1'b0),
        .load_data ('0),
        .adv       (1'b0),
        .wr        (ct_wr_s),
        .wr_data   (ct_data),
        .word      (ct_word_unused_s),
        .block     (ct_block_s),
        .last      (ct_last_s)
    );

    // Next-state and per-cycle control strobes.
    always_comb begin
        next_state_s    = state_r;
        accept_s        = 1'b0;
        key_done_s      = 1'b0;
        timeout_s       = 1'b0;
        out_load_s      = 1'b0;
        out_load_data_s = '0;
        out_adv_s       = 1'b0;
        ct_clr_s        = 1'b0;
        ct_wr_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept_s   = 1'b1;
                    out_load_s = 1'b1;
                    ct_clr_s   = 1'b1;
                    // Reuse is only honoured when a key is known to be loaded
                    if (cmd_reuse_key && key_loaded_r) begin
                        out_load_data_s = cmd_pt;
                        next_state_s    = ST_LOAD_PT;
                    end else begin
                        out_load_data_s = cmd_key;
                        next_state_s    = ST_LOAD_KEY;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD_KEY: begin
                if (key_ready && out_last_s) begin
                    // Key done: swap the held plaintext into the shift buffer
                    key_done_s      = 1'b1;
                    out_load_s      = 1'b1;
                    out_load_data_s = pt_hold_r;
                    next_state_s    = ST_LOAD_PT;
                end else if (key_ready) begin
                    out_adv_s = 1'b1;
                end else begin
                    next_state_s = ST_LOAD_KEY;
                end
            end
            ST_LOAD_PT: begin
                if (pt_ready) begin
                    out_adv_s = 1'b1;
                    if (out_last_s) begin
                        next_state_s = ST_WAIT_CT;
                    end else begin
                        next_state_s = ST_LOAD_PT;
                    end
                end else begin
                    next_state_s = ST_LOAD_PT;
                end
            end
            ST_WAIT_CT: begin
                // A handshake on the terminal-count cycle wins over the abort
                if (ct_valid) begin
                    ct_wr_s = 1'b1;
                    if (ct_last_s) begin
                        next_state_s = ST_RESP;
                    end else begin
                        next_state_s = ST_WAIT_CT;
                    end
                end else if (to_cnt_r == TO_W'(TIMEOUT - 1)) begin
                    // This idle cycle is the TIMEOUT-th in a row
                    timeout_s    = 1'b1;
                    ct_clr_s     = 1'b1;
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT_CT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Plaintext captured at accept so the shift buffer can carry the key first.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pt_hold_r <= '0;
        end else if (accept_s) begin
            pt_hold_r <= cmd_pt;
        end else begin
            pt_hold_r <= pt_hold_r;
        end
    end

    // Tracks whether the AES core holds a valid key; lost on timeout.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            key_loaded_r <= 1'b0;
        end else if (key_done_s) begin
            key_loaded_r <= 1'b1;
        end else if (timeout_s) begin
            key_loaded_r <= 1'b0;
        end else begin
            key_loaded_r <= key_loaded_r;
        end
    end

    // Consecutive idle cycles in WAIT_CT; cleared by any ct handshake.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            to_cnt_r <= '0;
        end else if ((state_r == ST_WAIT_CT) && !ct_valid && !timeout_s) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= '0;
        end
    end

    // Error flag for the pending response.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rsp_err_r <= 1'b0;
        end else if (timeout_s) begin
            rsp_err_r <= 1'b1;
        end else if ((state_r == ST_RESP) && rsp_ready) begin
            rsp_err_r <= 1'b0;
        end else begin
            rsp_err_r <= rsp_err_r;
        end
    end

    assign cmd_ready = (state_r == ST_IDLE);
    assign key_valid = (state_r == ST_LOAD_KEY);
    assign key_data  = key_valid ? out_word_s : '0;
    assign key_last  = key_valid && out_last_s;
    assign pt_valid  = (state_r == ST_LOAD_PT);
    assign pt_data   = pt_valid ? out_word_s : '0;
    assign ct_ready  = (state_r == ST_WAIT_CT);
    assign rsp_valid = (state_r == ST_RESP);
    // Gather buffer is cleared on abort, so an error response carries zero
    assign rsp_ct    = rsp_valid ? ct_block_s : '0;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_aes_bus_master.sv
module tb_aes_bus_master;
    import aes_bus_master_pkg::*;

    localparam int TO = 16;
    localparam block_t KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam block_t PT  = 128'h00112233445566778899aabbccddeeff;
    localparam block_t CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam block_t KEY_ALT = 128'hdeadbeef_cafef00d_01234567_89abcdef;

    logic   clk = 1'b0;
    logic   resetN;
    logic   cmd_valid, cmd_ready, cmd_reuse_key;
    block_t cmd_key, cmd_pt;
    logic   key_valid, key_ready, key_last;
    word_t  key_data;
    logic   pt_valid, pt_ready;
    word_t  pt_data;
    logic   ct_valid, ct_ready;
    word_t  ct_data;
    logic   rsp_valid, rsp_ready, rsp_err;
    block_t rsp_ct;

    always #5 clk = ~clk;

    aes_bus_master #(.WORD_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .resetN(resetN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key),
        .cmd_pt(cmd_pt), .cmd_reuse_key(cmd_reuse_key),
        .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
        .key_last(key_last),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
        .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ct(rsp_ct),
        .rsp_err(rsp_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stall_pct = 0;

    logic [32:0]  exp_key_q [$];   // {last, word}
    word_t        exp_pt_q  [$];
    logic [128:0] exp_rsp_q [$];   // {err, ct}
    word_t        slave_ct_q [$];

    int key_valid_cnt, key_hs_cnt, pt_hs_cnt, ct_idle_cnt;
    int first_key_cyc, first_pt_cyc, last_ct_cyc, rsp_first_cyc, accept_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: transfer with nothing expected", name);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk({tag, "_flags"}, {key_valid, key_last, pt_valid, ct_ready, rsp_valid, rsp_err}, 6'd0);
        chk({tag, "_key_data"}, key_data, 32'd0);
        chk({tag, "_pt_data"}, pt_data, 32'd0);
        chk({tag, "_rsp_ct"}, rsp_ct, 128'd0);
    endtask

    // Slave model: ready/valid generation with optional random stalls.
    initial begin
        bit ct_hs;
        key_ready = 1'b0; pt_ready = 1'b0; ct_valid = 1'b0; ct_data = '0;
        forever begin
            @(negedge clk);
            ct_hs = ct_valid && ct_ready;
            @(posedge clk);
            #1;
            if (ct_hs && slave_ct_q.size() > 0) void'(slave_ct_q.pop_front());
            key_ready = ($urandom_range(0, 99) >= stall_pct);
            pt_ready  = ($urandom_range(0, 99) >= stall_pct);
            if (slave_ct_q.size() > 0 && ($urandom_range(0, 99) >= stall_pct)) begin
                ct_valid = 1'b1;
                ct_data  = slave_ct_q[0];
            end else begin
                ct_valid = 1'b0;
                ct_data  = '0;
            end
        end
    end

    // Monitor / scoreboard: compares every presented word against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (resetN) begin
                if (key_valid) begin
                    key_valid_cnt++;
                    if (first_key_cyc < 0) first_key_cyc = cyc;
                    if (exp_key_q.size() == 0) unexpected("key_word");
                    else begin
                        chk("key_data", key_data, exp_key_q[0][31:0]);
                        chk("key_last", key_last, exp_key_q[0][32]);
                        if (key_ready) begin
                            void'(exp_key_q.pop_front());
                            key_hs_cnt++;
                        end
                    end
                end
                if (pt_valid) begin
                    if (first_pt_cyc < 0) first_pt_cyc = cyc;
                    if (exp_pt_q.size() == 0) unexpected("pt_word");
                    else begin
                        chk("pt_data", pt_data, exp_pt_q[0]);
                        if (pt_ready) begin
                            void'(exp_pt_q.pop_front());
                            pt_hs_cnt++;
                        end
                    end
                end
                if (ct_valid && ct_ready) last_ct_cyc = cyc;
                if (ct_ready && !ct_valid) ct_idle_cnt++;
                if (rsp_valid) begin
                    if (rsp_first_cyc < 0) rsp_first_cyc = cyc;
                    if (exp_rsp_q.size() == 0) unexpected("rsp");
                    else begin
                        chk("rsp_err", rsp_err, exp_rsp_q[0][128]);
                        chk("rsp_ct", rsp_ct, exp_rsp_q[0][127:0]);
                        if (rsp_ready) void'(exp_rsp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic issue(input block_t key, input block_t pt, input logic reuse,
                         input bit full, input bit err, input block_t ct);
        key_valid_cnt = 0; key_hs_cnt = 0; pt_hs_cnt = 0; ct_idle_cnt = 0;
        first_key_cyc = -1; first_pt_cyc = -1; last_ct_cyc = -1;
        rsp_first_cyc = -1; accept_cyc = -1;
        if (full) for (int i = 0; i < 4; i++) exp_key_q.push_back({(i == 3), key[i*32 +: 32]});
        for (int i = 0; i < 4; i++) exp_pt_q.push_back(pt[i*32 +: 32]);
        if (!err) for (int i = 0; i < 4; i++) slave_ct_q.push_back(ct[i*32 +: 32]);
        exp_rsp_q.push_back({err, err ? 128'd0 : ct});
        @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_key = key; cmd_pt = pt; cmd_reuse_key = reuse;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                accept_cyc = cyc;
                break;
            end
        end
        chk("cmd_accepted", (accept_cyc >= 0), 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_key = '0; cmd_pt = '0; cmd_reuse_key = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_key_q.size() + exp_pt_q.size() + exp_rsp_q.size()) != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_pending"}, exp_key_q.size() + exp_pt_q.size() + exp_rsp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0; cmd_valid = 1'b0; cmd_key = '0; cmd_pt = '0;
        cmd_reuse_key = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 resetN = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1'b1);

        // Full key load, zero-wait slave
        issue(KEY, PT, 1'b0, 1'b1, 1'b0, CT);
        wait_done("full");
        chk("full_key_hs", key_hs_cnt, 4);
        chk("lat_key_first", first_key_cyc, accept_cyc + 1);
        chk("lat_pt_first", first_pt_cyc, accept_cyc + 5);
        chk("lat_rsp_after_ct", rsp_first_cyc, last_ct_cyc + 1);
        chk("lat_rsp_total", rsp_first_cyc, accept_cyc + 13);

        // Key reuse: no key words, pt right after accept
        issue(KEY_ALT, PT, 1'b1, 1'b0, 1'b0, CT);
        wait_done("reuse");
        chk("reuse_key_cycles", key_valid_cnt, 0);
        chk("reuse_pt_first", first_pt_cyc, accept_cyc + 1);

        // Random stalls on every bus
        stall_pct = 30;
        issue(KEY, PT, 1'b0, 1'b1, 1'b0, CT);
        wait_done("stall");
        chk("stall_key_hs", key_hs_cnt, 4);
        stall_pct = 0;

        // Slave never answers: timeout abort
        issue(KEY, PT, 1'b1, 1'b0, 1'b1, 128'd0);
        wait_done("timeout");
        chk("timeout_idle_cycles", ct_idle_cnt, TO);

        // Reuse after timeout forces full key load; consumer stalls 10 cycles
        rsp_ready = 1'b0;
        issue(KEY, PT, 1'b1, 1'b1, 1'b0, CT);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        for (int k = 0; k < 10; k++) begin
            chk("hold_rsp_valid", rsp_valid, 1'b1);
            chk("hold_rsp_ct", rsp_ct, CT);
            chk("hold_cmd_ready", cmd_ready, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_done("post_timeout");
        chk("post_timeout_key_hs", key_hs_cnt, 4);

        // Reset while plaintext word 2 is on the bus
        issue(KEY, PT, 1'b1, 1'b0, 1'b0, CT);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            #1;
            if (pt_hs_cnt >= 2) break;
        end
        @(posedge clk);
        #1;
        chk("mid_reset_pt_words", pt_hs_cnt, 2);
        resetN = 1'b0;
        exp_pt_q.delete(); exp_rsp_q.delete(); slave_ct_q.delete();
        @(negedge clk);
        check_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 resetN = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_rsp_after_reset", rsp_first_cyc, -1);

        // Key knowledge lost across reset: reuse performs full key load
        issue(KEY, PT, 1'b1, 1'b1, 1'b0, CT);
        wait_done("after_reset");
        chk("after_reset_key_hs", key_hs_cnt, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
